// File: rtl/keypad_instruction_entry.sv
// Keypad instruction entry: scans a 4x4 active-low hex keypad one column at a
// time, debounces presses and releases over whole scan frames, and shifts each
// accepted hex digit into a 12-bit instruction word {op, A, B}.
//
// Ports:
//   CLK100MHZ     in   system clock
//   reset_n       in   synchronous active-low reset
//   row[3:0]      in   keypad rows, active-low, already synchronised
//   col[3:0]      out  keypad columns, active-low, exactly one low
//   clear         in   synchronous clear of instructions/digit_count
//   instructions  out  [11:8] op, [7:4] A, [3:0] B, newest digit in [3:0]
//   key_code      out  hex value of the last accepted key
//   key_valid     out  one-cycle pulse per accepted key
//   digit_count   out  digits entered since reset/clear, saturating at 3
`timescale 1ns / 1ps

module keypad_instruction_entry #(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        CLK100MHZ,
  input  logic        reset_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  input  logic        clear,
  output logic [11:0] instructions,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [1:0]  digit_count
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DivW-1:0] DivLast   = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntTarget = CntW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {StIdle, StCandidate, StPressed} state_e;
  typedef enum logic [1:0] {FrNone, FrSingle, FrMulti} frame_e;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
      4'hC: key_map = 4'h0;  4'hD: key_map = 4'hF;  4'hE: key_map = 4'hE;  default: key_map = 4'hD;
    endcase
  endfunction

  // Column scan
  logic [DivW-1:0] r_div;
  logic [1:0]      r_col_idx;
  logic            w_sample;

  assign w_sample = (r_div == DivLast);
  assign col      = ~(4'b0001 << r_col_idx);

  always_ff @(posedge CLK100MHZ) begin
    if (!reset_n) begin
      r_div     <= '0;
      r_col_idx <= 2'd0;
    end else if (w_sample) begin
      r_div     <= '0;
      r_col_idx <= r_col_idx + 2'd1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Frame accumulator: counts row/column intersections (saturating at 2)
  // and remembers the code of the first one seen.
  logic [3:0] w_row_low;
  logic [2:0] w_hits;
  logic [1:0] w_hit_row;
  logic [3:0] w_hit_code;
  logic [2:0] w_total;
  logic [1:0] w_acc_n_next;
  logic [3:0] w_acc_code_next;
  logic [1:0] r_acc_n;
  logic [3:0] r_acc_code;
  frame_e     r_frame_kind;
  logic [3:0] r_frame_code;
  logic       r_frame_done;

  assign w_row_low = ~row;
  assign w_hits    = {2'b00, w_row_low[0]} + {2'b00, w_row_low[1]}
                   + {2'b00, w_row_low[2]} + {2'b00, w_row_low[3]};

  always_comb begin
    w_hit_row = 2'd0;
    if      (w_row_low[0]) w_hit_row = 2'd0;
    else if (w_row_low[1]) w_hit_row = 2'd1;
    else if (w_row_low[2]) w_hit_row = 2'd2;
    else if (w_row_low[3]) w_hit_row = 2'd3;
  end

  assign w_hit_code      = key_map(w_hit_row, r_col_idx);
  assign w_total         = {1'b0, r_acc_n} + w_hits;
  assign w_acc_n_next    = (w_total >= 3'd2) ? 2'd2 : w_total[1:0];
  assign w_acc_code_next = (r_acc_n == 2'd0) ? w_hit_code : r_acc_code;

  always_ff @(posedge CLK100MHZ) begin
    if (!reset_n) begin
      r_acc_n      <= 2'd0;
      r_acc_code   <= 4'h0;
      r_frame_kind <= FrNone;
      r_frame_code <= 4'h0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_sample) begin
        if (r_col_idx == 2'd3) begin
          r_frame_done <= 1'b1;
          r_frame_code <= w_acc_code_next;
          r_frame_kind <= (w_acc_n_next == 2'd0) ? FrNone :
                          (w_acc_n_next == 2'd1) ? FrSingle : FrMulti;
          r_acc_n      <= 2'd0;
          r_acc_code   <= 4'h0;
        end else begin
          r_acc_n    <= w_acc_n_next;
          r_acc_code <= w_acc_code_next;
        end
      end
    end
  end

  // Debounce FSM; r_cnt counts stable press frames in StCandidate and
  // release frames in StPressed.
  state_e          r_state, w_state_next;
  logic [CntW-1:0] r_cnt, w_cnt_next, w_cnt_inc;
  logic [3:0]      r_code, w_code_next;
  logic            w_accept;

  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge CLK100MHZ) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_code  <= 4'h0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_code  <= w_code_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_code_next  = r_code;
    w_accept     = 1'b0;
    if (r_frame_done) begin
      unique case (r_state)
        StIdle: begin
          if (r_frame_kind == FrSingle) begin
            w_code_next = r_frame_code;
            if (DEBOUNCE_SCANS == 1) begin
              w_accept     = 1'b1;
              w_state_next = StPressed;
              w_cnt_next   = '0;
            end else begin
              w_state_next = StCandidate;
              w_cnt_next   = CntW'(1);
            end
          end
        end
        StCandidate: begin
          if (r_frame_kind == FrSingle) begin
            if (r_frame_code == r_code) begin
              if (w_cnt_inc == CntTarget) begin
                w_accept     = 1'b1;
                w_state_next = StPressed;
                w_cnt_next   = '0;
              end else begin
                w_cnt_next = w_cnt_inc;
              end
            end else begin
              w_code_next = r_frame_code;
              w_cnt_next  = CntW'(1);
            end
          end else begin
            w_state_next = StIdle;
            w_cnt_next   = '0;
          end
        end
        StPressed: begin
          if (r_frame_kind == FrNone) begin
            if (w_cnt_inc == CntTarget) begin
              w_state_next = StIdle;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next = w_cnt_inc;
            end
          end else begin
            // Any key still down restarts the release count; no auto-repeat.
            w_cnt_next = '0;
          end
        end
        default: begin
          w_state_next = StIdle;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  // Output datapath; clear overrides a coincident accept.
  logic [11:0] r_instr, w_instr_next;
  logic [1:0]  r_digits, w_digits_next;
  logic [3:0]  r_key_code, w_key_code_next;
  logic        r_key_valid, w_key_valid_next;

  always_comb begin
    w_instr_next     = r_instr;
    w_digits_next    = r_digits;
    w_key_code_next  = r_key_code;
    w_key_valid_next = 1'b0;
    if (w_accept) begin
      w_key_code_next  = r_frame_code;
      w_instr_next     = {r_instr[7:0], r_frame_code};
      w_digits_next    = (r_digits == 2'd3) ? 2'd3 : r_digits + 2'd1;
      w_key_valid_next = 1'b1;
    end
    if (clear) begin
      w_instr_next     = 12'h000;
      w_digits_next    = 2'd0;
      w_key_valid_next = 1'b0;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!reset_n) begin
      r_instr     <= 12'h000;
      r_digits    <= 2'd0;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
    end else begin
      r_instr     <= w_instr_next;
      r_digits    <= w_digits_next;
      r_key_code  <= w_key_code_next;
      r_key_valid <= w_key_valid_next;
    end
  end

  assign instructions = r_instr;
  assign digit_count  = r_digits;
  assign key_code     = r_key_code;
  assign key_valid    = r_key_valid;

endmodule

// File: tb/tb_keypad_instruction_entry.sv
// Bench for keypad_instruction_entry with SCAN_DIV=4, DEBOUNCE_SCANS=2
// (one scan frame = 16 cycles). A behavioural keypad drives the rows from
// the set of held keys; expected key_valid pulses are queued by the stimulus
// and checked by an independent monitor.
`timescale 1ns / 1ps

module tb_keypad_instruction_entry;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [11:0] instructions;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [1:0]  digit_count;

  logic [15:0] held;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [17:0] exp_q[$];  // {key_code, instructions, digit_count}

  always #5 clk = ~clk;

  keypad_instruction_entry #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .CLK100MHZ   (clk),
    .reset_n     (reset_n),
    .row         (row),
    .col         (col),
    .clear       (clear),
    .instructions(instructions),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .digit_count (digit_count)
  );

  // Physical keypad layout.
  function automatic logic [3:0] pad_code(input int r, input int c);
    case (r * 4 + c)
      0: return 4'h1;   1: return 4'h2;   2: return 4'h3;   3: return 4'hA;
      4: return 4'h4;   5: return 4'h5;   6: return 4'h6;   7: return 4'hB;
      8: return 4'h7;   9: return 4'h8;  10: return 4'h9;  11: return 4'hC;
      12: return 4'h0; 13: return 4'hF;  14: return 4'hE;  default: return 4'hD;
    endcase
  endfunction

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (held[pad_code(r, c)] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every key_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got key_code=%0h instructions=%03h, required no pulse",
                 key_code, instructions);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        check("pulse_key_code", 32'(key_code), 32'(e[17:14]));
        check("pulse_instructions", 32'(instructions), 32'(e[13:2]));
        check("pulse_digit_count", 32'(digit_count), 32'(e[1:0]));
      end
    end
  end

  task automatic hold_frames(input int n);
    repeat (16 * n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k, input int frames);
    held = 16'h0001 << k;
    hold_frames(frames);
  endtask

  task automatic release_keys(input int frames);
    held = 16'h0000;
    hold_frames(frames);
  endtask

  task automatic expect_key(input logic [3:0] k, input logic [11:0] ins, input logic [1:0] cnt);
    exp_q.push_back({k, ins, cnt});
  endtask

  logic [3:0] walk_exp[4];

  initial begin
    reset_n = 1'b0;
    clear   = 1'b0;
    held    = 16'h0000;
    walk_exp = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    repeat (3) @(posedge clk);
    #1;
    check("reset_col", 32'(col), 32'h0000_000E);
    check("reset_instructions", 32'(instructions), 32'h0);
    check("reset_key_code", 32'(key_code), 32'h0);
    check("reset_key_valid", 32'(key_valid), 32'h0);
    check("reset_digit_count", 32'(digit_count), 32'h0);

    // Column walk: one step every 4 cycles, ending back on column 0 at the
    // frame boundary, which keeps all later stimulus frame-aligned.
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(posedge clk);
      #1;
      check("col_walk", 32'(col), 32'(walk_exp[i]));
    end

    // '5' held 3 frames: exactly one pulse.
    expect_key(4'h5, 12'h005, 2'd1);
    press(4'h5, 3);
    release_keys(2);

    expect_key(4'hA, 12'h05A, 2'd2);
    press(4'hA, 2);
    release_keys(2);
    expect_key(4'h3, 12'h5A3, 2'd3);
    press(4'h3, 2);
    release_keys(2);
    check("three_digits_instr", 32'(instructions), 32'h5A3);
    check("three_digits_count", 32'(digit_count), 32'd3);

    // Fourth digit shifts out the oldest.
    expect_key(4'hC, 12'hA3C, 2'd3);
    press(4'hC, 2);
    release_keys(2);
    check("fourth_digit_count", 32'(digit_count), 32'd3);

    // One-frame glitch and a two-key chord: both rejected.
    press(4'h7, 1);
    release_keys(2);
    held = (16'h0001 << 1) | (16'h0001 << 2);
    hold_frames(3);
    release_keys(2);
    check("reject_instr", 32'(instructions), 32'hA3C);

    // Release bounce on '9' gives a single pulse; a later press is new.
    expect_key(4'h9, 12'h3C9, 2'd3);
    press(4'h9, 2);
    release_keys(1);
    press(4'h9, 2);
    release_keys(2);
    expect_key(4'h9, 12'hC99, 2'd3);
    press(4'h9, 2);
    release_keys(2);
    check("after_bounce_instr", 32'(instructions), 32'hC99);

    // clear lands on the accept edge of 'F' (end of frame 2 plus one cycle).
    held = 16'h0001 << 4'hF;
    repeat (32) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clear_instr", 32'(instructions), 32'h0);
    check("clear_count", 32'(digit_count), 32'h0);
    check("clear_key_valid", 32'(key_valid), 32'h0);
    repeat (15) @(posedge clk);
    #1;
    release_keys(2);
    check("clear_held_instr", 32'(instructions), 32'h0);

    // Reset while 'D' is mid-debounce; it needs two fresh frames afterwards.
    held = 16'h0001 << 4'hD;
    hold_frames(1);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midreset_key_code", 32'(key_code), 32'h0);
    check("midreset_col", 32'(col), 32'h0000_000E);
    reset_n = 1'b1;
    hold_frames(1);
    repeat (2) @(posedge clk);
    #1;
    expect_key(4'hD, 12'h00D, 2'd1);
    repeat (14) @(posedge clk);
    #1;
    release_keys(2);
    check("final_instr", 32'(instructions), 32'h00D);

    hold_frames(1);
    check("pulses_outstanding", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
